// File: rtl/psi_table_scheduler.sv
// Periodic PSI/SI table scheduler: per-table repetition timers on a ms tick, fixed-priority
// selection (PAT > PMT > SDT) and a READY/START/SENT handshake with a watchdog toward the packer.
module psi_table_scheduler #(
  parameter int unsigned TICK_DIV    = 27000,
  parameter int unsigned PAT_MS      = 100,
  parameter int unsigned PMT_MS      = 100,
  parameter int unsigned SDT_MS      = 1000,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic       START,
  input  logic       TABLE_SENT,
  input  logic       CLR_ERR,
  output logic       TABLE_READY,
  output logic [1:0] TABLE_SEL,
  output logic [2:0] OVERRUN,
  output logic       TIMEOUT_ERR,
  output logic [1:0] state_mon
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t        r_state, w_state_nx;
  logic [PW-1:0] r_presc;
  logic [10:0]   r_cnt [3];
  logic [10:0]   w_lim [3];
  logic [2:0]    r_pend, r_ovr;
  logic          r_en_d, r_to;
  logic [1:0]    r_sel, w_sel_nx;
  logic [WW-1:0] r_wd, w_wd_nx;
  logic          w_tick, w_en_rise, w_accept, w_to_set;
  logic [2:0]    w_exp, w_clr, w_pend_nx;

  assign w_lim[0]  = 11'(PAT_MS - 1);
  assign w_lim[1]  = 11'(PMT_MS - 1);
  assign w_lim[2]  = 11'(SDT_MS - 1);
  assign w_tick    = ENABLE && (r_presc == PW'(TICK_DIV - 1));
  assign w_en_rise = ENABLE && !r_en_d;
  assign w_accept  = (r_state == S_OFFER) && ENABLE && START;

  always_comb begin
    w_exp = '0;
    w_clr = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      w_exp[i] = w_tick && (r_cnt[i] == w_lim[i]);
      w_clr[i] = w_accept && (r_sel == 2'(i));
    end
  end

  // A same-cycle expiry re-arms the table being cleared, so it is not an overrun.
  assign w_pend_nx = ENABLE ? ((r_pend & ~w_clr) | w_exp | {3{w_en_rise}}) : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_en_d  <= 1'b0;
      r_presc <= '0;
      r_pend  <= '0;
      for (int unsigned i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_en_d <= ENABLE;
      r_pend <= w_pend_nx;
      if (!ENABLE || w_tick) r_presc <= '0;
      else                   r_presc <= r_presc + PW'(1);
      for (int unsigned i = 0; i < 3; i++) begin
        if (!ENABLE)    r_cnt[i] <= '0;
        else if (w_tick) r_cnt[i] <= w_exp[i] ? '0 : r_cnt[i] + 11'd1;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_wd_nx    = r_wd;
    w_to_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ENABLE && (|r_pend)) begin
          w_state_nx = S_OFFER;
          w_sel_nx   = r_pend[0] ? 2'd0 : (r_pend[1] ? 2'd1 : 2'd2);
        end
      end
      S_OFFER: begin
        if (!ENABLE) begin
          w_state_nx = S_IDLE;
        end else if (START) begin
          w_state_nx = S_BUSY;
          w_wd_nx    = '0;
        end
      end
      S_BUSY: begin
        if (TABLE_SENT) begin
          w_state_nx = S_IDLE;
        end else if (r_wd == WW'(TIMEOUT_CYC - 1)) begin
          w_to_set   = 1'b1;
          w_state_nx = S_IDLE;
        end else begin
          w_wd_nx = r_wd + WW'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_wd    <= '0;
      r_ovr   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
      r_wd    <= w_wd_nx;
      r_ovr   <= (CLR_ERR ? 3'b000 : r_ovr) | (w_exp & r_pend & ~w_clr);
      r_to    <= (CLR_ERR ? 1'b0 : r_to) | w_to_set;
    end
  end

  assign TABLE_READY = (r_state == S_OFFER);
  assign TABLE_SEL   = r_sel;
  assign OVERRUN     = r_ovr;
  assign TIMEOUT_ERR = r_to;
  assign state_mon   = r_state;

endmodule
